// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants and types for the pipeline sequencer.
//   - Stop/NonStop encoding and the four legal stall vectors. Bit order:
//     [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
//   - MIPS-style exception codes reported by the MEM stage.
//   - FSM state encoding for pipe_ctrl.
//   - redirect_pc(): chooses the restart address for an exception.
// No ports: this is a package.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NONSTOP = 1'b0;

    // A stall request freezes its own stage and every stage upstream of it.
    // The stages downstream keep moving, so a bubble is inserted behind the
    // stalled stage.
    localparam logic [STALL_W-1:0] STALL_NONE = {NONSTOP, NONSTOP, NONSTOP,
                                                 NONSTOP, NONSTOP, NONSTOP};
    localparam logic [STALL_W-1:0] STALL_ID   = {NONSTOP, NONSTOP, NONSTOP,
                                                 STOP,    STOP,    STOP};
    localparam logic [STALL_W-1:0] STALL_EX   = {NONSTOP, NONSTOP, STOP,
                                                 STOP,    STOP,    STOP};
    localparam logic [STALL_W-1:0] STALL_MEM  = {NONSTOP, STOP,    STOP,
                                                 STOP,    STOP,    STOP};

    // Exception codes delivered by MEM. Only EXC_NONE and EXC_ERET change
    // how this block behaves. Every other non-zero code is redirected to
    // the common vector.
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    // ERET resumes at the saved EPC. Every other exception enters the handler.
    function automatic logic [31:0] redirect_pc(input logic [31:0] exc,
                                                input logic [31:0] epc,
                                                input logic [31:0] vector);
        return (exc == EXC_ERET) ? epc : vector;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline stages and the sequencer.
//   stallreq_from_id/ex/mem : per-stage stall requests
//   excepttype              : exception code from MEM (0 = none)
//   cp0_epc                 : EPC used as the ERET target
//   stall[5:0]              : per-stage Stop vector back to the stage registers
//   flush                   : clear all pipeline registers on this edge
//   new_pc                  : redirect target, meaningful while flush=1
// Modports:
//   master : the core side, which drives requests and consumes control
//   slave  : the sequencer (pipe_ctrl)
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic               stallreq_from_id;
    logic               stallreq_from_ex;
    logic               stallreq_from_mem;
    logic [31:0]        excepttype;
    logic [31:0]        cp0_epc;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;

    modport master (
        output stallreq_from_id,
        output stallreq_from_ex,
        output stallreq_from_mem,
        output excepttype,
        output cp0_epc,
        input  stall,
        input  flush,
        input  new_pc
    );

    modport slave (
        input  stallreq_from_id,
        input  stallreq_from_ex,
        input  stallreq_from_mem,
        input  excepttype,
        input  cp0_epc,
        output stall,
        output flush,
        output new_pc
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog
// Detects a runaway stall. It counts consecutive stalled cycles, saturates at
// TIMEOUT_CYCLES, and raises a sticky flag afterwards.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   stall[5:0]     : stall vector currently applied to the pipeline
//   flush          : flush pulse currently applied to the pipeline
//   timeout_clr    : clears stall_timeout on the next edge (a set wins)
//   stall_timeout  : sticky runaway-stall flag
// -----------------------------------------------------------------------------
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               timeout_clr,
    output logic               stall_timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             timeout_nxt;
    logic             stalled;

    assign stalled = (stall != STALL_NONE) && !flush;

    always_comb begin
        cnt_nxt = cnt;
        if (!stalled) begin
            cnt_nxt = '0;
        end else if (cnt != LIMIT) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // The flag is raised during the cycle after the counter has saturated.
    // A pending clear cannot hide a stall that is still running away.
    always_comb begin
        timeout_nxt = stall_timeout;
        if (cnt == LIMIT) begin
            timeout_nxt = 1'b1;
        end else if (timeout_clr) begin
            timeout_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            stall_timeout <= timeout_nxt;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer for the 5-stage core. It merges the ID/EX/MEM stall
// requests into the stall vector, turns MEM exceptions into a one-cycle flush
// with a redirect PC, and then drops everything for one RECOVER cycle while
// the flushed bubbles drain.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : stall requests, exception info, stall/flush/new_pc out
//   timeout_clr    : clears stall_timeout
//   stall_timeout  : sticky runaway-stall flag from stall_watchdog
//   stall_cycles   : free-running count of cycles with stall[0]=1
//                    (present only when STALL_PERF_CNT_EN is defined)
// Build option:
//   STALL_PERF_CNT_EN - adds the stall_cycles performance counter and its port.
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus,
    input  logic        timeout_clr,
    output logic        stall_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [STALL_W-1:0] stall_c;
    logic               flush_c;
    logic [31:0]        new_pc_c;

    // The outputs are combinational because pc_reg and the stage registers
    // act on the same edge as the request. The outputs are also gated by rst
    // so that they go to zero while reset is asserted, without waiting for
    // a clock edge.
    always_comb begin
        state_nxt = state;
        stall_c   = STALL_NONE;
        flush_c   = 1'b0;
        new_pc_c  = 32'h0;
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    if (bus.excepttype != EXC_NONE) begin
                        flush_c   = 1'b1;
                        new_pc_c  = redirect_pc(bus.excepttype, bus.cp0_epc,
                                                EXC_VECTOR);
                        state_nxt = ST_RECOVER;
                    end else if (bus.stallreq_from_mem) begin
                        stall_c = STALL_MEM;
                    end else if (bus.stallreq_from_ex) begin
                        stall_c = STALL_EX;
                    end else if (bus.stallreq_from_id) begin
                        stall_c = STALL_ID;
                    end
                end
                // Every request in this cycle comes from the wrong path or
                // from a bubble. An exception here cannot be real because
                // MEM holds a flushed bubble.
                ST_RECOVER: begin
                    state_nxt = ST_RUN;
                end
                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign bus.stall  = stall_c;
    assign bus.flush  = flush_c;
    assign bus.new_pc = new_pc_c;

    stall_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall_c),
        .flush         (flush_c),
        .timeout_clr   (timeout_clr),
        .stall_timeout (stall_timeout)
    );

`ifdef STALL_PERF_CNT_EN
    // The counter wraps naturally at 2^32. A flush does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'h0;
        end else if (stall_c[0] == STOP) begin
            stall_cycles <= stall_cycles + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. A behavioural reference model predicts
// stall/flush/new_pc/stall_timeout (and stall_cycles when the feature is
// built in). Each predicted value is queued when stimulus is applied and
// popped and compared at the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TO = 8;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        timeout;
        logic [31:0] perf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        timeout_clr;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    pipe_ctrl_if bus();

    pipe_ctrl #(
        .EXC_VECTOR     (32'h0000_0020),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .timeout_clr   (timeout_clr),
        .stall_timeout (stall_timeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

`ifndef STALL_PERF_CNT_EN
    assign stall_cycles = 32'h0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    // Reference model state
    logic        m_recover;
    int          m_cnt;
    logic        m_to;
    logic [31:0] m_perf;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_recover = 1'b0;
        m_cnt     = 0;
        m_to      = 1'b0;
        m_perf    = 32'h0;
        sb.delete();
    endtask

    // Apply one cycle of stimulus. Predict, compare at the falling edge, then
    // advance the model on the rising edge. Entered and left at posedge+1.
    task automatic step(input string tag, input logic id, input logic ex,
                        input logic mem, input logic [31:0] exc,
                        input logic [31:0] epc, input logic clr);
        exp_t e;
        exp_t g;
        bus.stallreq_from_id  = id;
        bus.stallreq_from_ex  = ex;
        bus.stallreq_from_mem = mem;
        bus.excepttype        = exc;
        bus.cp0_epc           = epc;
        timeout_clr           = clr;

        e.stall  = 6'b000000;
        e.flush  = 1'b0;
        e.new_pc = 32'h0;
        if (!m_recover) begin
            if (exc != 32'h0) begin
                e.flush  = 1'b1;
                e.new_pc = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
            end else if (mem) e.stall = 6'b011111;
            else if (ex)      e.stall = 6'b001111;
            else if (id)      e.stall = 6'b000111;
        end
        e.timeout = m_to;
        e.perf    = m_perf;
        sb.push_back(e);

        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, ":sb_empty"}, 32'h1, 32'h0);
        end else begin
            g = sb.pop_front();
            chk({tag, ":stall"},   {26'h0, bus.stall},    {26'h0, g.stall});
            chk({tag, ":flush"},   {31'h0, bus.flush},    {31'h0, g.flush});
            chk({tag, ":new_pc"},  bus.new_pc,            g.new_pc);
            chk({tag, ":timeout"}, {31'h0, stall_timeout}, {31'h0, g.timeout});
`ifdef STALL_PERF_CNT_EN
            chk({tag, ":perf"},    stall_cycles,          g.perf);
`endif
        end

        @(posedge clk);
        // Advance the model with the inputs that were sampled on this edge.
        if (m_cnt == TO)          m_to = 1'b1;
        else if (clr)             m_to = 1'b0;
        if (e.stall == 6'b0 || e.flush) m_cnt = 0;
        else if (m_cnt < TO)            m_cnt = m_cnt + 1;
        if (e.stall[0])           m_perf = m_perf + 32'h1;
        m_recover = !m_recover && e.flush;
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();

        // Reset asserted while requests and an exception are present
        rst                   = 1'b1;
        timeout_clr           = 1'b0;
        bus.stallreq_from_id  = 1'b1;
        bus.stallreq_from_ex  = 1'b1;
        bus.stallreq_from_mem = 1'b1;
        bus.excepttype        = 32'h0000_0008;
        bus.cp0_epc           = 32'h0000_1234;
        #2;
        chk("rst:stall",   {26'h0, bus.stall}, 32'h0);
        chk("rst:flush",   {31'h0, bus.flush}, 32'h0);
        chk("rst:new_pc",  bus.new_pc,         32'h0);
        chk("rst:timeout", {31'h0, stall_timeout}, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst                   = 1'b0;
        bus.stallreq_from_id  = 1'b0;
        bus.stallreq_from_ex  = 1'b0;
        bus.stallreq_from_mem = 1'b0;
        bus.excepttype        = 32'h0;
        @(posedge clk);
        #1;

        idle("idle", 3);

        // ID and EX together; EX wins
        for (int i = 0; i < 3; i++) step("id_ex", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle("id_ex_done", 1);
`ifdef STALL_PERF_CNT_EN
        chk("perf_after_3", stall_cycles, 32'd3);
`endif
        step("id_only", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step("all_req", 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0);

        // ERET with a simultaneous MEM stall, then RECOVER, then RUN
        step("eret",    1'b0, 1'b0, 1'b1, 32'h0000_000e, 32'h0000_1234, 1'b0);
        step("recov",   1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1234, 1'b0);
        step("post_rc", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        idle("idle2", 1);

        // Syscall held into RECOVER produces no second flush
        step("sys",      1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_5678, 1'b0);
        step("sys_held", 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_5678, 1'b0);
        idle("idle3", 1);

        // Runaway stall: 12 cycles of EX busy
        for (int i = 0; i < 12; i++) step("to_ex", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle("to_drop", 2);
        chk("to_sticky", {31'h0, stall_timeout}, 32'h1);
        step("to_clr", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle("to_cleared", 1);
        chk("to_after_clr", {31'h0, stall_timeout}, 32'h0);

        // Clear held while the set condition fires: set wins
        for (int i = 0; i < 11; i++) step("to_setclr", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("to_set_wins", {31'h0, stall_timeout}, 32'h1);

        // Async reset while stalled with the flag set
        rst = 1'b1;
        #1;
        chk("arst_stall:stall",   {26'h0, bus.stall}, 32'h0);
        chk("arst_stall:timeout", {31'h0, stall_timeout}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_stall:run", {26'h0, bus.stall}, 32'h0000_000f);
        model_reset();
        step("after_arst1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        idle("idle4", 1);

        // Async reset in the RECOVER cycle
        step("exc_ov", 1'b0, 1'b0, 1'b0, 32'h0000_000c, 32'h0, 1'b0);
        bus.stallreq_from_mem = 1'b1;
        bus.excepttype        = 32'h0;
        #1;
        chk("recov_hold:stall", {26'h0, bus.stall}, 32'h0);
        rst = 1'b1;
        #1;
        chk("arst_rc:stall", {26'h0, bus.stall}, 32'h0);
        chk("arst_rc:flush", {31'h0, bus.flush}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_rc:run", {26'h0, bus.stall}, 32'h0000_001f);
        model_reset();
        step("after_arst2", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        idle("final", 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges stall requests from ID, EX and MEM into the 6-bit stall vector consumed by pc_reg and every inter-stage register (if_id … mem_wb). It turns exceptions detected in MEM into a flush pulse and a redirect PC. It also tracks stall duration, flags runaway stalls, and optionally counts stall cycles.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for every exception except ERET
TIMEOUT_CYCLES, 1024, consecutive stalled cycles before stall_timeout sets
CNT_W, 11, width of the consecutive-stall counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
stallreq_from_id  input  1  ID needs a bubble (load-use)
stallreq_from_ex  input  1  EX multi-cycle op busy (div/madd)
stallreq_from_mem  input  1  MEM bus wait
excepttype  input  32  exception code from MEM; 0 = none
cp0_epc  input  32  EPC value for ERET
stall  output  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = Stop
flush  output  1  clear all pipeline registers this edge
new_pc  output  32  redirect target, valid while flush=1
stall_timeout  output  1  sticky runaway-stall flag
timeout_clr  input  1  clears stall_timeout
stall_cycles  output  32  stall-cycle counter (only with the optional feature)

Behaviour:
- FSM has two states, RUN and RECOVER. Reset state is RUN. The counter resets to 0 and stall_timeout resets to 0. While rst is asserted, stall, flush and new_pc are 0.
- stall, flush and new_pc are combinational from the current inputs and state. This gives zero latency, because the stage registers act on the same edge.
- RUN, excepttype != 0:
  - flush=1 and stall=6'b000000.
  - new_pc=cp0_epc if excepttype==32'h0000_000e (ERET), else EXC_VECTOR.
  - Next state is RECOVER.
- RUN, no exception: priority is MEM > EX > ID.
  - stallreq_from_mem gives stall=6'b011111.
  - else stallreq_from_ex gives 6'b001111.
  - else stallreq_from_id gives 6'b000111.
  - else 6'b000000.
  - flush=0 and new_pc=0.
- RECOVER lasts exactly one cycle:
  - flush=0, stall=0, and all inputs are ignored.
  - Wrong-path requests are dropped while the flushed bubbles drain.
  - Next state is RUN.
- An exception wins over any simultaneous stall request.
- Back-to-back exceptions: an exception present in the RECOVER cycle is ignored. It cannot be real, because MEM holds a bubble in that cycle.
- Consecutive-stall counter:
  - Increments every cycle with stall != 0 and saturates at TIMEOUT_CYCLES.
  - Clears to 0 on any cycle with stall==0 or flush==1.
- stall_timeout sets on the cycle after the counter reaches TIMEOUT_CYCLES. It stays set until timeout_clr=1, which clears it on the next edge. If set and clear conditions coincide, set wins.
- rst asserted mid-stall or mid-RECOVER returns the block to RUN immediately and clears all state.

Optional Feature:
STALL_PERF_CNT_EN
- Defined:
  - stall_cycles is a 32-bit free-running counter that increments on every cycle with stall[0]==1.
  - It wraps from 32'hFFFF_FFFF to 0, resets to 0, and is not cleared by flush.
- Undefined: the stall_cycles port and its logic are absent.

Decomposition:
- Shared package/define file holds:
  - Stop/NonStop and stall vector constants: STALL_NONE, STALL_ID, STALL_EX, STALL_MEM.
  - Exception code constants: EXC_ERET = 32'h0000_000e, plus the others in use.
  - The FSM state encoding.
- One natural sub-module: stall_watchdog, covering the consecutive-stall counter, saturation and the sticky stall_timeout flag with timeout_clr.

Test Plan:
- Reset then idle, no requests: stall=6'b000000, flush=0, stall_timeout=0; with the feature, stall_cycles stays 0.
- stallreq_from_id and stallreq_from_ex both 1 for 3 cycles: stall=6'b001111 each cycle, then 6'b000000; with the feature, stall_cycles=3.
- excepttype=32'h0000_000e with cp0_epc=32'h0000_1234 and stallreq_from_mem=1: flush=1, new_pc=32'h0000_1234, stall=0. Next cycle flush=0, stall=0 although stallreq_from_mem is still 1. The cycle after, stall=6'b011111.
- excepttype=32'h0000_0008: new_pc=32'h0000_0020. The same code held into the following cycle gives no second flush.
- TIMEOUT_CYCLES=8, stallreq_from_ex held 12 cycles: stall_timeout rises after cycle 8 and stays set after the request drops. timeout_clr=1 clears it. timeout_clr and the set condition together leave it set.
- Async rst pulse mid-RECOVER and mid-stall: outputs go to 0 immediately without a clock edge, and the FSM is in RUN after release.
